// File: rtl/app_segment_xlate_pkg.sv
// Shared request types, system constants and segment-table reset values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package app_segment_xlate_pkg;

    localparam int AMI_NUM_PORTS = 4;
    localparam int AMI_NUM_APPS  = 8;
    localparam int AMI_APP_BITS  = 3;
    localparam int AMI_ADDR_W    = 64;

    typedef struct packed {
        logic                  valid;
        logic                  isWrite;
        logic [AMI_ADDR_W-1:0] addr;
        logic [63:0]           data;
        logic [6:0]            size;
    } AMIRequest;

    typedef struct packed {
        logic [AMI_ADDR_W-1:0] base;
        logic [AMI_ADDR_W-1:0] limit;
    } AppSegment;

    // Equal-partition map: entry i owns [i*2^(W-bits), (i+1)*2^(W-bits)).
    function automatic AppSegment default_segment(input int unsigned i,
                                                  input int unsigned app_bits = AMI_APP_BITS);
        AppSegment s;
        s.base  = AMI_ADDR_W'(i) << (AMI_ADDR_W - app_bits);
        s.limit = AMI_ADDR_W'(1) << (AMI_ADDR_W - app_bits);
        return s;
    endfunction

endpackage

// File: rtl/app_segment_xlate_if.sv
// Request/grant bundle between the app ports, the translator and the memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: reqAccepted throttles inReq; outReq_grant drains outReq.
// Ports: inReq/reqAccepted (upstream), outReq/outReq_grant (downstream).
// master = environment side (drives requests and grants), slave = translator.
interface app_segment_xlate_if #(
    parameter int NUM_PORTS = app_segment_xlate_pkg::AMI_NUM_PORTS
);
    import app_segment_xlate_pkg::*;

    AMIRequest [NUM_PORTS-1:0] inReq;
    logic      [NUM_PORTS-1:0] reqAccepted;
    AMIRequest [NUM_PORTS-1:0] outReq;
    logic      [NUM_PORTS-1:0] outReq_grant;

    modport master (output inReq, output outReq_grant, input reqAccepted, input outReq);
    modport slave  (input inReq, input outReq_grant, output reqAccepted, output outReq);

endinterface

// File: rtl/xlate_port_stage.sv
// One-entry registered output slice for a single port, with address relocation on load.
// Latency: 1 cycle from acceptance to out_req.valid.
// Backpressure: accepted only when enabled and the slot is empty or being granted.
// Ports: clk/rst_n, enabled, in_req, base (relocation), drop (bounds fault),
//        grant, accepted, out_req.
module xlate_port_stage
    import app_segment_xlate_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enabled,
    input  AMIRequest         in_req,
    input  logic [ADDR_W-1:0] base,
    input  logic              drop,
    input  logic              grant,
    output logic              accepted,
    output AMIRequest         out_req
);

    AMIRequest held_q;
    AMIRequest held_d;
    logic      xfer;

    always_comb begin
        accepted = rst_n && enabled && (!held_q.valid || grant);
        xfer     = in_req.valid && accepted;
        held_d   = held_q;
        if (xfer && !drop) begin
            held_d       = in_req;
            held_d.addr  = in_req.addr + base;   // wraps modulo 2^ADDR_W
            held_d.valid = 1'b1;
        end else if (grant) begin
            // Covers a dropped (faulting) transfer too: the slot empties.
            held_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_q <= '0;
        end else begin
            held_q <= held_d;
        end
    end

    // Output is forced to zero for the whole reset window, not just after the first edge.
    assign out_req = rst_n ? held_q : '0;

endmodule

// File: rtl/app_segment_xlate.sv
// Per-app address relocation (VA + base[app_num]) with optional bounds check and fault capture.
// Latency: 1 cycle per port (registered one-entry stage), 1 transfer/cycle/port.
// Backpressure: per-port reqAccepted drops while a held entry is not granted or enabled is low.
// Ports: clk, rst_n (sync, active-low), enabled, app_num, cfg_* table write port,
//        bus (slave: inReq/reqAccepted/outReq/outReq_grant), fault_* status, fault_clr.
// Build option: XLATE_BOUNDS_CHECK_EN adds limit registers, fault check, capture and counter.
module app_segment_xlate
    import app_segment_xlate_pkg::*;
#(
    parameter int NUM_PORTS = AMI_NUM_PORTS,
    parameter int NUM_APPS  = AMI_NUM_APPS,
    parameter int APP_BITS  = AMI_APP_BITS,
    parameter int ADDR_W    = 64,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enabled,
    input  logic [APP_BITS-1:0] app_num,
    input  logic                cfg_wr_en,
    input  logic [APP_BITS-1:0] cfg_app,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [ADDR_W-1:0]   cfg_limit,
    app_segment_xlate_if.slave  bus,
    output logic                fault_pending,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] fault_port,
    output logic [ADDR_W-1:0]   fault_addr,
    output logic [CNT_W-1:0]    fault_count,
    input  logic                fault_clr
);

    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int NCNT_W = $clog2(NUM_PORTS + 1);
    localparam int SUM_W  = CNT_W + 1;

    logic [ADDR_W-1:0]    rst_base [NUM_APPS];
    logic [ADDR_W-1:0]    base_q   [NUM_APPS];
    logic [ADDR_W-1:0]    base_d   [NUM_APPS];
    logic [ADDR_W-1:0]    cur_base;
    logic [NUM_PORTS-1:0] accepted;
    logic [NUM_PORTS-1:0] drop;
    AMIRequest            out_req  [NUM_PORTS];

    for (genvar a = 0; a < NUM_APPS; a++) begin : g_rst
        localparam AppSegment RST_SEG = default_segment(a, APP_BITS);
        assign rst_base[a] = RST_SEG.base;
    end

    // Table reads use the registered value, so a write never affects
    // a request accepted in the same cycle.
    always_comb begin
        for (int a = 0; a < NUM_APPS; a++) begin
            base_d[a] = base_q[a];
        end
        if (cfg_wr_en) begin
            base_d[cfg_app] = cfg_base;
        end
    end

    always_ff @(posedge clk) begin
        for (int a = 0; a < NUM_APPS; a++) begin
            if (!rst_n) begin
                base_q[a] <= rst_base[a];
            end else begin
                base_q[a] <= base_d[a];
            end
        end
    end

    assign cur_base = base_q[app_num];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        xlate_port_stage #(.ADDR_W(ADDR_W)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .enabled  (enabled),
            .in_req   (bus.inReq[p]),
            .base     (cur_base),
            .drop     (drop[p]),
            .grant    (bus.outReq_grant[p]),
            .accepted (accepted[p]),
            .out_req  (out_req[p])
        );
    end

    assign bus.reqAccepted = accepted;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.outReq[p] = out_req[p];
        end
    end

`ifdef XLATE_BOUNDS_CHECK_EN

    logic [ADDR_W-1:0]    rst_limit [NUM_APPS];
    logic [ADDR_W-1:0]    limit_q   [NUM_APPS];
    logic [ADDR_W-1:0]    limit_d   [NUM_APPS];
    logic [ADDR_W-1:0]    cur_limit;
    logic [NUM_PORTS-1:0] fault_vec;
    logic [NCNT_W-1:0]    nfault;
    logic [PORT_W-1:0]    first_port;
    logic [ADDR_W-1:0]    first_addr;
    logic                 pend_base;
    logic [CNT_W-1:0]     cnt_base;
    logic [SUM_W-1:0]     cnt_sum;

    logic                 fault_pending_q, fault_pending_d;
    logic [PORT_W-1:0]    fault_port_q, fault_port_d;
    logic [ADDR_W-1:0]    fault_addr_q, fault_addr_d;
    logic [CNT_W-1:0]     fault_count_q, fault_count_d;

    for (genvar a = 0; a < NUM_APPS; a++) begin : g_rst_lim
        localparam AppSegment RST_SEG = default_segment(a, APP_BITS);
        assign rst_limit[a] = RST_SEG.limit;
    end

    always_comb begin
        for (int a = 0; a < NUM_APPS; a++) begin
            limit_d[a] = limit_q[a];
        end
        if (cfg_wr_en) begin
            limit_d[cfg_app] = cfg_limit;
        end
    end

    always_ff @(posedge clk) begin
        for (int a = 0; a < NUM_APPS; a++) begin
            if (!rst_n) begin
                limit_q[a] <= rst_limit[a];
            end else begin
                limit_q[a] <= limit_d[a];
            end
        end
    end

    assign cur_limit = limit_q[app_num];

    // A faulting request still handshakes upstream; the stage just skips the load.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            drop[p]      = (bus.inReq[p].addr >= cur_limit);
            fault_vec[p] = bus.inReq[p].valid && accepted[p] && drop[p];
        end
    end

    // Scan high to low so the last hit left standing is the lowest-numbered port.
    always_comb begin
        nfault     = '0;
        first_port = '0;
        first_addr = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (fault_vec[p]) begin
                nfault     = nfault + NCNT_W'(1);
                first_port = PORT_W'(p);
                first_addr = bus.inReq[p].addr;
            end
        end
    end

    // Clear is applied first so that same-cycle faults land on a clean slate.
    always_comb begin
        pend_base       = fault_clr ? 1'b0 : fault_pending_q;
        cnt_base        = fault_clr ? '0   : fault_count_q;
        cnt_sum         = {1'b0, cnt_base} + SUM_W'(nfault);
        fault_pending_d = pend_base;
        fault_port_d    = fault_port_q;
        fault_addr_d    = fault_addr_q;
        fault_count_d   = cnt_base;
        if (|fault_vec) begin
            fault_pending_d = 1'b1;
            if (!pend_base) begin
                fault_port_d = first_port;
                fault_addr_d = first_addr;
            end
            fault_count_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_pending_q <= 1'b0;
            fault_port_q    <= '0;
            fault_addr_q    <= '0;
            fault_count_q   <= '0;
        end else begin
            fault_pending_q <= fault_pending_d;
            fault_port_q    <= fault_port_d;
            fault_addr_q    <= fault_addr_d;
            fault_count_q   <= fault_count_d;
        end
    end

    assign fault_pending = fault_pending_q;
    assign fault_port    = fault_port_q;
    assign fault_addr    = fault_addr_q;
    assign fault_count   = fault_count_q;

`else

    logic unused_cfg;

    assign drop          = '0;
    assign fault_pending = 1'b0;
    assign fault_port    = '0;
    assign fault_addr    = '0;
    assign fault_count   = '0;
    assign unused_cfg    = ^{cfg_limit, fault_clr};

`endif

endmodule
